// File: rtl/snake_score_keeper_if.sv
// ---------------------------------------------------------------------------
// snake_score_keeper_if
// Groups the game-event pulses, the display selector and the score outputs
// of snake_score_keeper into one bundle.
//   master : game logic / testbench side (drives the event pulses and the
//            high-score selector, observes the score outputs)
//   slave  : snake_score_keeper side
// Signals:
//   i_NewGame   - 1-cycle pulse, start or restart a game
//   i_FoodEaten - 1-cycle pulse, snake ate food
//   i_GameOver  - 1-cycle pulse, collision / game end
//   i_ShowHigh  - level, 1 shows the high score on o_Score
//   o_Score     - registered display value for the scoreboard
//   o_HighScore - registered session high score
//   o_Playing   - high while a game is running
//   o_NewHigh   - last finished game beat the previous high score
//   o_Streak    - current streak level (0 without the streak feature)
// ---------------------------------------------------------------------------
interface snake_score_keeper_if #(
  parameter int SCORE_WIDTH = 14
);
  logic                   i_NewGame;
  logic                   i_FoodEaten;
  logic                   i_GameOver;
  logic                   i_ShowHigh;
  logic [SCORE_WIDTH-1:0] o_Score;
  logic [SCORE_WIDTH-1:0] o_HighScore;
  logic                   o_Playing;
  logic                   o_NewHigh;
  logic [2:0]             o_Streak;

  modport master (
    output i_NewGame, i_FoodEaten, i_GameOver, i_ShowHigh,
    input  o_Score, o_HighScore, o_Playing, o_NewHigh, o_Streak
  );

  modport slave (
    input  i_NewGame, i_FoodEaten, i_GameOver, i_ShowHigh,
    output o_Score, o_HighScore, o_Playing, o_NewHigh, o_Streak
  );
endinterface

// File: rtl/snake_score_keeper.sv
// ---------------------------------------------------------------------------
// snake_score_keeper
// Tracks the snake game lifecycle (idle / play / over), accumulates points on
// food pulses with saturation at SCORE_MAX, keeps a session high score and
// selects current or high score for the four-digit scoreboard.
// Ports:
//   i_Clk   - system clock, rising edge
//   i_Reset - synchronous active-high reset (clears the high score too)
//   bus     - snake_score_keeper_if.slave (event pulses in, scores out)
// Optional feature: define SNAKE_SCORE_STREAK_EN to enable the food streak
// multiplier (points = POINTS_PER_FOOD * (1 + streak)). Without it there is
// no streak timer and o_Streak is constant 0.
// ---------------------------------------------------------------------------
module snake_score_keeper #(
  parameter int SCORE_WIDTH     = 14,
  parameter int SCORE_MAX       = 9999,
  parameter int POINTS_PER_FOOD = 1,
  parameter int STREAK_WINDOW   = 50000000,
  parameter int STREAK_MAX      = 4,
  parameter int TIMER_WIDTH     = 26
) (
  input logic                i_Clk,
  input logic                i_Reset,
  snake_score_keeper_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam logic [SCORE_WIDTH:0]   SCORE_MAX_WIDE = (SCORE_WIDTH+1)'(SCORE_MAX);
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX_VAL  = SCORE_WIDTH'(SCORE_MAX);

  state_t                 state_r;
  state_t                 next_state_s;
  logic [SCORE_WIDTH-1:0] score_r;
  logic [SCORE_WIDTH-1:0] high_r;
  logic                   new_high_r;
  logic                   playing_r;
  logic [SCORE_WIDTH-1:0] display_r;
  logic [2:0]             streak_out_r;

  logic                   new_game_s;
  logic                   game_over_s;
  logic                   food_s;
  logic [SCORE_WIDTH:0]   pts_s;
  logic [SCORE_WIDTH:0]   sum_s;
  logic [2:0]             streak_next_s;
  logic [SCORE_WIDTH-1:0] score_next_s;
  logic [SCORE_WIDTH-1:0] high_next_s;
  logic                   new_high_next_s;
  logic                   playing_next_s;
  logic [SCORE_WIDTH-1:0] display_next_s;

  // Accepted events after priority NewGame > GameOver > FoodEaten; game-over
  // and food only count while playing.
  assign new_game_s  = bus.i_NewGame;
  assign game_over_s = (state_r == S_PLAY) && bus.i_GameOver && !bus.i_NewGame;
  assign food_s      = (state_r == S_PLAY) && bus.i_FoodEaten && !bus.i_GameOver
                       && !bus.i_NewGame;

`ifdef SNAKE_SCORE_STREAK_EN
  localparam logic [2:0]             STREAK_MAX_VAL = 3'(STREAK_MAX);
  localparam logic [TIMER_WIDTH-1:0] TIMER_RELOAD   = TIMER_WIDTH'(STREAK_WINDOW - 1);

  logic [TIMER_WIDTH-1:0] timer_r;
  logic [TIMER_WIDTH-1:0] timer_next_s;
  logic [2:0]             streak_r;

  // Streak timer/level: food inside the window raises the streak, window
  // expiry drops it; both hold outside play and on the game-over cycle.
  always_comb begin
    timer_next_s  = timer_r;
    streak_next_s = streak_r;
    if (new_game_s) begin
      timer_next_s  = {TIMER_WIDTH{1'b0}};
      streak_next_s = 3'd0;
    end else if (food_s) begin
      if (timer_r != {TIMER_WIDTH{1'b0}}) begin
        streak_next_s = (streak_r >= STREAK_MAX_VAL) ? STREAK_MAX_VAL : streak_r + 3'd1;
      end else begin
        streak_next_s = 3'd0;
      end
      timer_next_s = TIMER_RELOAD;
    end else if ((state_r == S_PLAY) && !game_over_s && (timer_r != {TIMER_WIDTH{1'b0}})) begin
      timer_next_s = timer_r - TIMER_WIDTH'(1);
      if (timer_r == TIMER_WIDTH'(1)) begin
        streak_next_s = 3'd0;
      end else begin
        streak_next_s = streak_r;
      end
    end else begin
      timer_next_s  = timer_r;
      streak_next_s = streak_r;
    end
  end

  // Streak timer and level registers.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      timer_r  <= {TIMER_WIDTH{1'b0}};
      streak_r <= 3'd0;
    end else begin
      timer_r  <= timer_next_s;
      streak_r <= streak_next_s;
    end
  end

  // Points use the streak value after this cycle's update.
  assign pts_s = (SCORE_WIDTH+1)'(POINTS_PER_FOOD * (int'(streak_next_s) + 1));
`else
  assign streak_next_s = 3'd0;
  assign pts_s         = (SCORE_WIDTH+1)'(POINTS_PER_FOOD);
`endif

  // Widened by one bit so the add cannot wrap before the saturation compare.
  assign sum_s = {1'b0, score_r} + pts_s;

  // FSM state register.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (new_game_s) next_state_s = S_PLAY;
        else            next_state_s = S_IDLE;
      end
      S_PLAY: begin
        if (new_game_s)       next_state_s = S_PLAY;
        else if (game_over_s) next_state_s = S_OVER;
        else                  next_state_s = S_PLAY;
      end
      S_OVER: begin
        if (new_game_s) next_state_s = S_PLAY;
        else            next_state_s = S_OVER;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // FSM output logic: next values of score, high score, flags and display.
  always_comb begin
    score_next_s    = score_r;
    high_next_s     = high_r;
    new_high_next_s = new_high_r;
    if (new_game_s) begin
      score_next_s    = {SCORE_WIDTH{1'b0}};
      new_high_next_s = 1'b0;
    end else if (game_over_s) begin
      if (score_r > high_r) begin
        high_next_s     = score_r;
        new_high_next_s = 1'b1;
      end else begin
        new_high_next_s = 1'b0;
      end
    end else if (food_s) begin
      if (sum_s > SCORE_MAX_WIDE) score_next_s = SCORE_MAX_VAL;
      else                        score_next_s = sum_s[SCORE_WIDTH-1:0];
    end else begin
      score_next_s = score_r;
    end
    playing_next_s = (next_state_s == S_PLAY);
    display_next_s = bus.i_ShowHigh ? high_next_s : score_next_s;
  end

  // Score, high score and output registers.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      score_r      <= {SCORE_WIDTH{1'b0}};
      high_r       <= {SCORE_WIDTH{1'b0}};
      new_high_r   <= 1'b0;
      playing_r    <= 1'b0;
      display_r    <= {SCORE_WIDTH{1'b0}};
      streak_out_r <= 3'd0;
    end else begin
      score_r      <= score_next_s;
      high_r       <= high_next_s;
      new_high_r   <= new_high_next_s;
      playing_r    <= playing_next_s;
      display_r    <= display_next_s;
      streak_out_r <= streak_next_s;
    end
  end

  assign bus.o_Score     = display_r;
  assign bus.o_HighScore = high_r;
  assign bus.o_Playing   = playing_r;
  assign bus.o_NewHigh   = new_high_r;
  assign bus.o_Streak    = streak_out_r;

endmodule

// File: tb/tb_snake_score_keeper.sv
// ---------------------------------------------------------------------------
// tb_snake_score_keeper
// Directed-vector bench. Each stimulus cycle may push a hand-computed expected
// output set into a queue, tagged with the cycle at which it must be visible;
// an independent monitor samples the DUT on every falling edge and pops and
// compares due entries. Build with SNAKE_SCORE_STREAK_EN for the streak
// sequence (short streak window), without it for the base sequence.
// ---------------------------------------------------------------------------
module tb_snake_score_keeper;
  localparam int W = 14;
`ifdef SNAKE_SCORE_STREAK_EN
  localparam int WIN = 8;
`else
  localparam int WIN = 50000000;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  snake_score_keeper_if #(.SCORE_WIDTH(W)) bus ();

  snake_score_keeper #(
    .SCORE_WIDTH(W), .SCORE_MAX(9999), .POINTS_PER_FOOD(1),
    .STREAK_WINDOW(WIN), .STREAK_MAX(4), .TIMER_WIDTH(26)
  ) dut (
    .i_Clk  (clk),
    .i_Reset(rst),
    .bus    (bus)
  );

  typedef struct {
    int due;
    int score;
    int high;
    int playing;
    int newhigh;
    int streak;
  } exp_t;

  exp_t  q[$];
  string tags[$];
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;
  exp_t  mon_e;
  string mon_t;

  // Cycle counter; inputs driven after edge N are visible after edge N+1.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that has fallen due.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      mon_e = q.pop_front();
      mon_t = tags.pop_front();
      checks++;
      if (int'(bus.o_Score) != mon_e.score || int'(bus.o_HighScore) != mon_e.high ||
          int'(bus.o_Playing) != mon_e.playing || int'(bus.o_NewHigh) != mon_e.newhigh ||
          int'(bus.o_Streak) != mon_e.streak) begin
        errors++;
        $display("FAIL %s: got score=%0d high=%0d playing=%0d newhigh=%0d streak=%0d, expected score=%0d high=%0d playing=%0d newhigh=%0d streak=%0d",
                 mon_t, bus.o_Score, bus.o_HighScore, bus.o_Playing, bus.o_NewHigh, bus.o_Streak,
                 mon_e.score, mon_e.high, mon_e.playing, mon_e.newhigh, mon_e.streak);
      end
    end
  end

  task automatic tick(input bit r, input bit n, input bit f, input bit g, input bit s);
    @(posedge clk);
    #1;
    rst             = r;
    bus.i_NewGame   = n;
    bus.i_FoodEaten = f;
    bus.i_GameOver  = g;
    bus.i_ShowHigh  = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_exp(input string tag, input int score, input int high,
                          input int pl, input int nh, input int st);
    exp_t e;
    e.due = cyc + 1; e.score = score; e.high = high;
    e.playing = pl; e.newhigh = nh; e.streak = st;
    q.push_back(e);
    tags.push_back(tag);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_NewGame = 1'b0; bus.i_FoodEaten = 1'b0;
    bus.i_GameOver = 1'b0; bus.i_ShowHigh = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp("reset", 0, 0, 0, 0, 0);
    idle(1);
`ifdef SNAKE_SCORE_STREAK_EN
    begin
      int st_tab[6] = '{0, 1, 2, 3, 4, 4};
      int sc_tab[6] = '{1, 3, 6, 10, 15, 20};
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); push_exp("ng", 0, 0, 1, 0, 0);
      for (int k = 0; k < 6; k++) begin
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        push_exp($sformatf("streak_food%0d", k), sc_tab[k], 0, 1, 0, st_tab[k]);
        if (k < 5) idle(3);
      end
      idle(9);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); push_exp("after_gap", 21, 0, 1, 0, 0);
      idle(3);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); push_exp("regrow", 23, 0, 1, 0, 1);
      idle(6);
      push_exp("before_expiry", 23, 0, 1, 0, 1);
      idle(1);
      push_exp("expiry", 23, 0, 1, 0, 0);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); push_exp("food_after_expiry", 24, 0, 1, 0, 0);
      idle(2);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); push_exp("streak_again", 26, 0, 1, 0, 1);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); push_exp("over", 26, 26, 0, 1, 1);
      idle(4);
      push_exp("frozen_in_over", 26, 26, 0, 1, 1);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); push_exp("ng_clears_streak", 0, 26, 1, 0, 0);
    end
`else
    // Basic scoring, one-cycle latency
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); push_exp("newgame", 0, 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); push_exp($sformatf("food%0d", k), k, 0, 1, 0, 0);
      idle(4);
    end
    // High score across two games
    for (int k = 4; k <= 12; k++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); push_exp($sformatf("g1_food%0d", k), k, 0, 1, 0, 0);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); push_exp("over1", 12, 12, 0, 1, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); push_exp("ng2", 0, 12, 1, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); push_exp($sformatf("g2_food%0d", k), k, 12, 1, 0, 0);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); push_exp("over2", 7, 12, 0, 0, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); push_exp("show_high", 12, 12, 0, 0, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); push_exp("show_cur", 7, 12, 0, 0, 0);
    // Food coincident with game-over, food in S_OVER
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); push_exp("ng3", 0, 12, 1, 0, 0);
    for (int k = 1; k <= 5; k++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_exp("g3_score5", 5, 12, 1, 0, 0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0); push_exp("food_with_over", 5, 12, 0, 0, 0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); push_exp("food_in_over", 5, 12, 0, 0, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); push_exp("ng_from_over", 0, 12, 1, 0, 0);
    // NewGame beats GameOver: restart stays in play
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); push_exp("g4_food1", 1, 12, 1, 0, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0); push_exp("ng_beats_over", 0, 12, 1, 0, 0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); push_exp("after_restart", 1, 12, 1, 0, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); push_exp("over_low", 1, 12, 0, 0, 0);
    // Reset mid-game at 40 with high 55
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 55; k++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); push_exp("over55", 55, 55, 0, 1, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); push_exp("ng_after55", 0, 55, 1, 0, 0);
    for (int k = 1; k <= 40; k++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_exp("score40", 40, 55, 1, 0, 0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); push_exp("reset_mid", 0, 0, 0, 0, 0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); push_exp("food_in_idle", 0, 0, 0, 0, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); push_exp("over_in_idle", 0, 0, 0, 0, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0); push_exp("ng_after_reset", 0, 0, 1, 0, 0);
    // Saturation at 9999
    for (int k = 1; k <= 9998; k++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push_exp("score9998", 9998, 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); push_exp($sformatf("sat%0d", k), 9999, 0, 1, 0, 0);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); push_exp("over_sat", 9999, 9999, 0, 1, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1); push_exp("ng_show_high", 9999, 9999, 1, 0, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); push_exp("ng_show_cur", 0, 9999, 1, 0, 0);
`endif
    idle(3);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
